// File: rtl/lab3_pkg.sv
// Shared types and constants for the display multiplexing scheduler.
package lab3_pkg;

    typedef enum logic [1:0] {
        BLANK0,
        SHOW0,
        BLANK1,
        SHOW1
    } disp_state_t;

    localparam logic [1:0] ENABLE_NONE = 2'b00;
    localparam logic [1:0] ENABLE_D0   = 2'b01;
    localparam logic [1:0] ENABLE_D1   = 2'b10;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/slot_timer.sv
// Slot-length counter shared by all scheduler slots; reloaded to zero on each slot entry.
module slot_timer #(
    parameter int unsigned  MAX = 2,
    localparam int unsigned CW  = $clog2(MAX),
    localparam int unsigned LW  = $clog2(MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [LW-1:0] len,
    output logic          done,
    output logic [CW-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    // High on the final cycle of a slot of length len.
    assign done = (LW'(count) == len - LW'(1));

endmodule

// File: rtl/display_mux_scheduler.sv
// Time-shares one seven-segment decoder between two digits holding the two most recent keys,
// with a dark gap between lit slots to prevent ghosting.
module display_mux_scheduler
    import lab3_pkg::*;
#(
    parameter int unsigned REFRESH_CYCLES = 24000,
    parameter int unsigned BLANK_CYCLES   = 48
) (
    input  logic       int_osc,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [3:0] hex_digit,
    output logic [1:0] enable_seg,
    output logic [7:0] digits,
    output logic       frame_done
);

    localparam int unsigned MAX_CYCLES = max_u(REFRESH_CYCLES, BLANK_CYCLES);
    localparam int unsigned CW         = $clog2(MAX_CYCLES);
    localparam int unsigned LW         = $clog2(MAX_CYCLES + 1);

    disp_state_t   state;
    disp_state_t   state_next;
    logic [CW-1:0] count;
    logic [LW-1:0] slot_len;
    logic          slot_done;
    logic          blank_first;
    logic [7:0]    snap;
    logic [7:0]    snap_next;
    logic [3:0]    hex_next;
    logic [1:0]    enable_next;
    logic          frame_done_next;

    assign slot_len = ((state == SHOW0) || (state == SHOW1)) ? LW'(REFRESH_CYCLES)
                                                             : LW'(BLANK_CYCLES);

    slot_timer #(.MAX(MAX_CYCLES)) u_slot_timer (
        .clk   (int_osc),
        .rst   (reset),
        .load  (slot_done),
        .len   (slot_len),
        .done  (slot_done),
        .count (count)
    );

    // Snapshot only on the first cycle of a blank slot so a lit digit never changes mid-slot.
    assign blank_first = ((state == BLANK0) || (state == BLANK1)) && (count == '0);
    assign snap_next   = blank_first ? digits : snap;

    always_ff @(posedge int_osc or posedge reset) begin
        if (reset) begin
            state <= BLANK0;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (slot_done) begin
            case (state)
                BLANK0: state_next = SHOW0;
                SHOW0:  state_next = BLANK1;
                BLANK1: state_next = SHOW1;
                SHOW1:  state_next = BLANK0;
            endcase
        end
    end

    // Outputs are computed from the upcoming state so the registers line up with it.
    always_comb begin
        enable_next     = ENABLE_NONE;
        hex_next        = snap_next[3:0];
        frame_done_next = (state == SHOW1) && (count == CW'(REFRESH_CYCLES - 2));
        case (state_next)
            BLANK0: hex_next = snap_next[3:0];
            SHOW0:  enable_next = ENABLE_D0;
            BLANK1: hex_next = snap_next[7:4];
            SHOW1: begin
                enable_next = ENABLE_D1;
                hex_next    = snap_next[7:4];
            end
        endcase
    end

    always_ff @(posedge int_osc or posedge reset) begin
        if (reset) begin
            snap       <= 8'h00;
            hex_digit  <= 4'h0;
            enable_seg <= ENABLE_NONE;
            frame_done <= 1'b0;
        end else begin
            snap       <= snap_next;
            hex_digit  <= hex_next;
            enable_seg <= enable_next;
            frame_done <= frame_done_next;
        end
    end

    // Two-entry key history: newest nibble enters at the bottom.
    always_ff @(posedge int_osc or posedge reset) begin
        if (reset) begin
            digits <= 8'h00;
        end else if (key_valid) begin
            digits <= {digits[3:0], key_code};
        end
    end

endmodule
